// File: rtl/pixel_pkg.sv
// Shared types for the pixel write sink: pixel beat layout, drain FSM states
// and the width helper for the linear address product.
package pixel_pkg;

  localparam int RGB_W   = 24;
  localparam int COORD_W = 10;

  typedef logic [RGB_W-1:0]   rgb_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    rgb_t   rgb;
    coord_t x;
    coord_t y;
  } pixel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_e;

  // Width that holds y*h_res + x without overflow for any 10-bit y and x.
  function automatic int lin_addr_w(input int h_res);
    return COORD_W + $clog2(h_res) + 1;
  endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Pixel write handshake between the burst writer (master) and the sink (slave):
// one beat transfers on each rising edge where WEN && ready.
interface pixel_write_sink_if;
  import pixel_pkg::*;

  logic   WEN;
  rgb_t   rgb_in;
  coord_t x_in;
  coord_t y_in;
  logic   ready;

  modport master (output WEN, output rgb_in, output x_in, output y_in, input ready);
  modport slave  (input WEN, input rgb_in, input x_in, input y_in, output ready);

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel beats with registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  pixel_t                     wr_data,
  input  logic                       pop,
  output pixel_t                     rd_data,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  pixel_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Pixel write sink: buffers incoming beats and drains them to a frame-buffer
// write port one at a time. Optional COORD_CHECK_EN drops off-screen beats.
module pixel_write_sink
  import pixel_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 19
) (
  input  logic              aclk,
  input  logic              aresetn,
  pixel_write_sink_if.slave pix,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [RGB_W-1:0]  mem_wdata,
  input  logic              mem_ack,
  output logic              frame_done
`ifdef COORD_CHECK_EN
  ,
  output logic              coord_err
`endif
);

  localparam int FRAME_PIX  = H_RES * V_RES;
  localparam int CNT_W      = $clog2(FRAME_PIX + 1);
  localparam int PROD_W     = lin_addr_w(H_RES);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  drain_state_e      state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  rgb_t              mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              ready_en_q;

  pixel_t                in_pix, head;
  logic                  accept, push, pop;
  logic                  fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [PROD_W-1:0]     lin_addr;

  // ready is held low in reset and comes only from flops, never from WEN or mem_ack.
  assign pix.ready = ready_en_q && !fifo_full;
  assign accept    = pix.WEN && pix.ready;
  assign in_pix    = '{rgb: pix.rgb_in, x: pix.x_in, y: pix.y_in};

`ifdef COORD_CHECK_EN
  logic in_range;
  logic coord_err_q;

  assign in_range  = (int'(pix.x_in) < H_RES) && (int'(pix.y_in) < V_RES);
  assign push      = accept && in_range;
  assign coord_err = coord_err_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) coord_err_q <= 1'b0;
    else          coord_err_q <= accept && !in_range;
  end
`else
  assign push = accept;
`endif

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push    (push),
    .wr_data (in_pix),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);
  assign pop        = (state_q == IDLE) && !fifo_empty;

  // Full-width product then truncation, so off-screen coordinates alias predictably.
  assign lin_addr = PROD_W'(head.y) * PROD_W'(H_RES) + PROD_W'(head.x);

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          mem_addr_d  = ADDR_W'(lin_addr);
          mem_wdata_d = head.rgb;
          mem_we_d    = 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          mem_we_d = 1'b0;
          state_d  = IDLE;
          if (pix_cnt_q == CNT_W'(FRAME_PIX - 1)) begin
            pix_cnt_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
      ready_en_q   <= 1'b1;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Scoreboard bench: a 640x480 sink and a 2x2 sink share one stimulus driver;
// expected writes are queued on acceptance and checked by per-DUT monitors.
module tb_pixel_write_sink;
  import pixel_pkg::*;

  localparam int AW = 19;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  pixel_write_sink_if pm ();
  pixel_write_sink_if ps ();

  logic        wen = 1'b0, sel = 1'b0;
  logic [9:0]  tx = 10'd1, ty = 10'd1;
  logic [23:0] trgb = '0;

  assign pm.WEN = wen & ~sel;
  assign pm.rgb_in = trgb;
  assign pm.x_in = tx;
  assign pm.y_in = ty;
  assign ps.WEN = wen & sel;
  assign ps.rgb_in = trgb;
  assign ps.x_in = tx;
  assign ps.y_in = ty;

  logic          m_we, s_we, m_fd, s_fd;
  logic          m_ack = 1'b0, s_ack = 1'b0;
  logic [AW-1:0] m_addr, s_addr;
  logic [23:0]   m_wdata, s_wdata;
`ifdef COORD_CHECK_EN
  logic m_cerr, s_cerr;
`endif

  pixel_write_sink #(.H_RES(640), .V_RES(480), .FIFO_DEPTH(8), .ADDR_W(AW)) dut_m (
    .aclk(aclk), .aresetn(aresetn), .pix(pm), .mem_we(m_we), .mem_addr(m_addr),
    .mem_wdata(m_wdata), .mem_ack(m_ack), .frame_done(m_fd)
`ifdef COORD_CHECK_EN
    , .coord_err(m_cerr)
`endif
  );

  pixel_write_sink #(.H_RES(2), .V_RES(2), .FIFO_DEPTH(8), .ADDR_W(AW)) dut_s (
    .aclk(aclk), .aresetn(aresetn), .pix(ps), .mem_we(s_we), .mem_addr(s_addr),
    .mem_wdata(s_wdata), .mem_ack(s_ack), .frame_done(s_fd)
`ifdef COORD_CHECK_EN
    , .coord_err(s_cerr)
`endif
  );

  int checks = 0, failures = 0;
  wr_t q_m[$], q_s[$];
  int ack_mode_m = 1, ack_mode_s = 2;
  int stall_cnt = 0, fd_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference address: linear pixel index modulo the memory size.
  function automatic logic [AW-1:0] model_addr(input int x, input int y, input int hres);
    longint a;
    a = longint'(y) * hres + x;
    return AW'(a % (longint'(1) << AW));
  endfunction

  function automatic logic pick_ack(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(0, 2) != 0);
  endfunction

  initial forever begin
    @(posedge aclk);
    #1;
    m_ack = pick_ack(ack_mode_m);
    s_ack = pick_ack(ack_mode_s);
  end

  // Monitor for the 640x480 sink.
  initial begin
    bit  active = 0;
    wr_t cur;
    forever begin
      @(negedge aclk);
      if (!aresetn) active = 0;
      else if (m_we) begin
        if (!active) begin
          if (q_m.size() == 0) begin
            check("m_unexpected_write", 1, 0);
            cur.addr = m_addr;
            cur.data = m_wdata;
          end else begin
            cur = q_m.pop_front();
            check("m_addr", m_addr, cur.addr);
            check("m_data", m_wdata, cur.data);
          end
        end else begin
          check("m_addr_stable", m_addr, cur.addr);
          check("m_data_stable", m_wdata, cur.data);
        end
        active = !m_ack;
      end else active = 0;
    end
  end

  // Monitor for the 2x2 sink, including the frame_done model.
  initial begin
    bit  active = 0;
    bit  fd_exp = 0;
    int  fcnt = 0;
    wr_t cur;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        active = 0;
        fd_exp = 0;
        fcnt = 0;
      end else begin
        check("s_frame_done", s_fd, fd_exp);
        if (s_fd) fd_seen++;
        fd_exp = 0;
        if (s_we) begin
          if (!active) begin
            if (q_s.size() == 0) begin
              check("s_unexpected_write", 1, 0);
              cur.addr = s_addr;
              cur.data = s_wdata;
            end else begin
              cur = q_s.pop_front();
              check("s_addr", s_addr, cur.addr);
              check("s_data", s_wdata, cur.data);
            end
          end else begin
            check("s_addr_stable", s_addr, cur.addr);
          end
          active = !s_ack;
          if (s_ack) begin
            fcnt++;
            if (fcnt == 4) begin
              fcnt = 0;
              fd_exp = 1;
            end
          end
        end else active = 0;
      end
    end
  end

  task automatic push_exp(input bit tgt, input int x, input int y, input logic [23:0] c);
    wr_t e;
    int  h, v;
    h = tgt ? 2 : 640;
    v = tgt ? 2 : 480;
    e.addr = model_addr(x, y, h);
    e.data = c;
`ifdef COORD_CHECK_EN
    if (x < h && y < v) begin
      if (tgt) q_s.push_back(e); else q_m.push_back(e);
    end
`else
    if (v > 0) begin
      if (tgt) q_s.push_back(e); else q_m.push_back(e);
    end
`endif
  endtask

  // Presents one beat and holds it until the selected sink takes it.
  task automatic send(input bit tgt, input int x, input int y, input logic [23:0] c);
    bit acc = 0;
    sel = tgt;
    tx = 10'(x);
    ty = 10'(y);
    trgb = c;
    wen = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge aclk);
      if (tgt ? ps.ready : pm.ready) begin
        acc = 1;
        push_exp(tgt, x, y, c);
      end else stall_cnt++;
      @(posedge aclk);
      #1;
    end
    if (!acc) check("send_timeout", 0, 1);
    wen = 1'b0;
    tx = 10'd1;
    ty = 10'd1;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (q_m.size() == 0 && q_s.size() == 0 && !m_we && !s_we) done = 1;
      else begin
        @(posedge aclk);
        #1;
      end
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int acc_n;
    int stale;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_ready_m", pm.ready, 0);
    check("rst_ready_s", ps.ready, 0);
    check("rst_mem_we", m_we, 0);
    check("rst_mem_addr", m_addr, 0);
    check("rst_mem_wdata", m_wdata, 0);
    check("rst_frame_done", s_fd, 0);
    @(negedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("ready_after_rst_m", pm.ready, 1);
    check("ready_after_rst_s", ps.ready, 1);

    // Four in-order beats with immediate acks; ready never drops.
    ack_mode_m = 1;
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) send(0, i, 0, 24'h112233 + 24'(i));
    check("t1_ready_held", stall_cnt, 0);
    wait_drain();

    // Bottom-right corner address, then two full 2x2 frames plus one extra pixel.
    send(0, 639, 479, 24'($urandom));
    for (int i = 0; i < 9; i++) send(1, i % 2, (i / 2) % 2, 24'($urandom));
    wait_drain();
    repeat (3) @(posedge aclk);
    #1;
    check("t3_frame_pulses", fd_seen, 2);

    // Off-screen column.
    send(0, 700, 3, 24'($urandom));
    send(0, 700, 479, 24'($urandom));
    wait_drain();

    // Memory stalled: FIFO plus one in flight, then release.
    ack_mode_m = 0;
    acc_n = 0;
    sel = 1'b0;
    wen = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tx = 10'(acc_n);
      ty = 10'd5;
      trgb = 24'hA00000 + 24'(acc_n);
      @(negedge aclk);
      if (pm.ready) begin
        push_exp(0, acc_n, 5, 24'hA00000 + 24'(acc_n));
        acc_n++;
      end
      @(posedge aclk);
      #1;
    end
    wen = 1'b0;
    check("t2_accepted", acc_n, 9);
    check("t2_ready_low", pm.ready, 0);
    @(negedge aclk);
    ack_mode_m = 1;
    @(posedge aclk);
    #2;
    @(posedge aclk);
    #2;
    check("t2_ready_after_ack", pm.ready, 0);
    @(posedge aclk);
    #2;
    check("t2_ready_after_pop", pm.ready, 1);
    wait_drain();

    // Randomised traffic with random acks and gaps.
    ack_mode_m = 2;
    for (int i = 0; i < 60; i++) begin
      send(0, $urandom_range(0, 1023), $urandom_range(0, 1023), 24'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge aclk);
      #1;
    end
    wait_drain();

    // Reset while a write is in flight with three beats buffered.
    ack_mode_m = 0;
    for (int i = 0; i < 4; i++) send(0, i, 7, 24'($urandom));
    repeat (3) @(posedge aclk);
    #3 aresetn = 1'b0;
    #1;
    check("t4_we_dropped", m_we, 0);
    check("t4_ready_in_rst", pm.ready, 0);
    q_m.delete();
    q_s.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    #1 aresetn = 1'b1;
    ack_mode_m = 1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (m_we) stale++;
    end
    check("t4_no_stale_writes", stale, 0);
    @(posedge aclk);
    #1;
    send(0, 10, 20, 24'h5A5A5A);
    send(0, 11, 20, 24'hA5A5A5);
    wait_drain();
    check("final_queue_m", q_m.size(), 0);
    check("final_queue_s", q_s.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
